camera_dvp_tx: RTL
==================

Name: camera_dvp_tx

Overview:
- Camera-side DVP transmitter (OV5640 emulator) that serialises a 16-bit pixel stream into 8-bit bytes, high byte first.
- Generates pclk, HREF-style hsync and active-high frame vsync, all in one fast clock domain.
- Drives the camera capture path on hardware loopback and in benches, so the receiver can be proven without a sensor.
- Pixel source is valid/ready; all timing comes from parameters.

Parameters:
- H_ACTIVE, 640: pixels per active line (2*H_ACTIVE byte slots with hs high).
- H_BLANK, 16: byte slots per line with hs low.
- VSYNC_LINES, 2: lines with vs low.
- VBACK_LINES, 2: lines with vs high and hs low, before the active lines.
- V_ACTIVE, 480: active lines.
- VFRONT_LINES, 2: lines with vs high and hs low, after the active lines.
- PCLK_DIV, 2 (min 1): clk_pixel_in cycles per pclk half-period.
- UNDERRUN_PIXEL, 16'h0000: pixel sent when the source is empty.

Ports:
- clk_pixel_in  in  1  system clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- enable_in  in  1  start and continue frames.
- pixel_in  in  16  pixel data, bits [15:8] sent first.
- valid_in  in  1  pixel_in valid.
- ready_out  out  1  pixel holding register empty.
- pclk_cam_out  out  1  generated pixel clock.
- hs_cam_out  out  1  line-active (HREF).
- vs_cam_out  out  1  frame-active.
- data_cam_out  out  8  byte bus.
- frame_start_out  out  1  one-cycle pulse on the first hi-byte slot of a frame.
- underrun_out  out  1  one-cycle pulse when UNDERRUN_PIXEL is substituted.

Behaviour:
- Reset is asynchronous, active-low (rst_n_in). In reset: pclk=0, hs=0, vs=0, data=0, frame_start=0, underrun=0, holding register empty (ready_out=1), state IDLE, all counters 0. Mid-frame reset truncates immediately and returns to these values; no partial line is resumed.
- pclk generation: divider counts 0..PCLK_DIV-1 and toggles pclk at terminal count, giving period 2*PCLK_DIV clk cycles. pclk runs continuously out of reset, including IDLE.
- Slot timing:
  - A "slot" = one pclk period.
  - On the clk edge where pclk goes 1->0, hs/vs/data/slot counters update together (registered).
  - Outputs are therefore stable PCLK_DIV cycles before and after each rising edge.
  - No output except pclk changes at the rising edge.
- Holding register:
  - ready_out = empty.
  - Load on valid_in && ready_out.
  - Consumed at the start of each hi-byte slot of an active line. If loaded and consumed in the same cycle, the consume uses the old contents (or the underrun path) and the load is kept.
- Hi-byte slot: data=pixel[15:8]; the lo byte is latched internally. Next slot: data=latched[7:0]. If empty at the hi-byte slot, send UNDERRUN_PIXEL and pulse underrun_out once per pixel.
- FSM, evaluated at slot boundaries (line = 2*H_ACTIVE+H_BLANK slots, counted by hcnt; vcnt counts lines within a state):
  - IDLE: vs=0, hs=0, data=0. Moves to VSYNC when enable_in=1.
  - VSYNC: vs=0. After VSYNC_LINES lines -> VBACK.
  - VBACK: vs=1, hs=0. After VBACK_LINES lines -> ACTIVE.
  - ACTIVE: vs=1. hs=1 for slots 0..2*H_ACTIVE-1, then hs=0 for H_BLANK slots. After V_ACTIVE lines -> VFRONT.
  - VFRONT: vs=1, hs=0. After VFRONT_LINES lines -> VSYNC if enable_in=1, else IDLE.
  - A zero-line count skips that state.
- Data is 8'h00 in every slot with hs=0.
- enable_in is sampled only in IDLE and at the end of VFRONT. Deassertion mid-frame completes the frame.
- frame_start_out pulses with the first hs-high slot of line 0.
- Counter widths: $clog2(max+1). No wrap occurs within a line or frame.

Decomposition:
- camera_dvp_pkg: state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT) and localparam helpers for line length and counter widths.
- One sub-module, dvp_pclk_gen: divider producing pclk_cam_out plus one-cycle fall_tick/rise_tick strobes.

Test Plan:
All scenarios use H_ACTIVE=4, H_BLANK=3, VSYNC/VBACK/VFRONT=1, V_ACTIVE=2, PCLK_DIV=2 (line 11 slots, 44 clk; frame 220 clk).
1. Reset, then release with enable_in=0 -> pclk toggles every 2 clk; hs=vs=data=0; ready_out=1.
2. enable_in=1, source always valid with pixels 16'h1234, 16'h5678, ... -> first hs-high slot is slot 22. Data sequence 12,34,56,78,... with hs high for exactly 8 slots per line. frame_start_out fires once. No underrun_out.
3. Loop back into the existing camera capture receiver -> 8 valid 16-bit words per frame, equal to the source words in order.
4. valid_in held low during line 0 -> 4 underrun_out pulses; bytes read 00 for those slots; vs/hs timing unchanged.
5. Drop enable_in during the ACTIVE state -> frame completes through VFRONT, then IDLE with vs=0; re-raise -> next VSYNC starts at the next slot boundary.
6. Assert rst_n_in mid-active line -> all outputs 0 asynchronously, no clk edge needed; after release, the next frame begins cleanly from VSYNC.

Source files
------------

// File: rtl/camera_dvp_pkg.sv
// Shared definitions for the DVP camera transmitter: FSM state codes and
// elaboration-time helpers for line length and counter sizing.
package camera_dvp_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StVsync  = 3'd1;
    localparam state_t StVback  = 3'd2;
    localparam state_t StActive = 3'd3;
    localparam state_t StVfront = 3'd4;

    // Byte slots per line: two bytes per active pixel plus horizontal blanking.
    function automatic int unsigned line_slots(input int unsigned h_active,
                                               input int unsigned h_blank);
        return 2 * h_active + h_blank;
    endfunction

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// Free-running pixel clock divider. pclk toggles every PCLK_DIV cycles of
// clk_in; fall/rise strobes are high in the cycle before the matching edge so
// the caller can update registers on exactly that clk edge.
module dvp_pclk_gen
    import camera_dvp_pkg::*;
#(
    parameter int unsigned PCLK_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic pclk_out,
    output logic fall_tick_out,
    output logic rise_tick_out
);

    localparam int unsigned DIV = (PCLK_DIV < 1) ? 1 : PCLK_DIV;
    localparam int unsigned DW  = cnt_width(DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          term;

    assign term = (div_q == DW'(DIV - 1));

    // Divider count and pclk toggle at terminal count.
    always_comb begin
        div_d  = term ? '0 : div_q + DW'(1);
        pclk_d = term ? ~pclk_q : pclk_q;
    end

    // Divider state; pclk starts low out of reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pclk_q <= pclk_d;
        end
    end

    assign pclk_out      = pclk_q;
    assign fall_tick_out = term & pclk_q;
    assign rise_tick_out = term & ~pclk_q;

endmodule

// File: rtl/camera_dvp_tx.sv
// OV5640-style DVP transmitter: serialises a 16-bit valid/ready pixel stream
// into hi/lo bytes with HREF-style hs and frame vs. All slot outputs change on
// the clk edge where pclk falls, so they are centred on the pclk rising edge.
module camera_dvp_tx
    import camera_dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE       = 640,
    parameter int unsigned H_BLANK        = 16,
    parameter int unsigned VSYNC_LINES    = 2,
    parameter int unsigned VBACK_LINES    = 2,
    parameter int unsigned V_ACTIVE       = 480,
    parameter int unsigned VFRONT_LINES   = 2,
    parameter int unsigned PCLK_DIV       = 2,
    parameter logic [15:0] UNDERRUN_PIXEL = 16'h0000
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic [15:0] pixel_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        pclk_cam_out,
    output logic        hs_cam_out,
    output logic        vs_cam_out,
    output logic [7:0]  data_cam_out,
    output logic        frame_start_out,
    output logic        underrun_out
);

    localparam int unsigned LINE = line_slots(H_ACTIVE, H_BLANK);
    localparam int unsigned HW   = cnt_width(LINE);
    localparam int unsigned VMAX = max4(VSYNC_LINES, VBACK_LINES, V_ACTIVE, VFRONT_LINES);
    localparam int unsigned VW   = cnt_width(VMAX);

    logic fall_tick, rise_tick;

    dvp_pclk_gen #(
        .PCLK_DIV (PCLK_DIV)
    ) u_pclk_gen (
        .clk_in        (clk_pixel_in),
        .rst_n_in      (rst_n_in),
        .pclk_out      (pclk_cam_out),
        .fall_tick_out (fall_tick),
        .rise_tick_out (rise_tick)
    );

    function automatic int unsigned state_lines(input state_t s);
        case (s)
            StVsync:  return VSYNC_LINES;
            StVback:  return VBACK_LINES;
            StActive: return V_ACTIVE;
            StVfront: return VFRONT_LINES;
            default:  return 0;
        endcase
    endfunction

    function automatic state_t succ(input state_t s, input logic en);
        case (s)
            StIdle:   return StVsync;
            StVsync:  return StVback;
            StVback:  return StActive;
            StActive: return StVfront;
            StVfront: return en ? StVsync : StIdle;
            default:  return StIdle;
        endcase
    endfunction

    // Successor state, stepping over any state configured with zero lines.
    function automatic state_t advance(input state_t s, input logic en);
        state_t n;
        n = succ(s, en);
        for (int i = 0; i < 4; i++) begin
            if (n != StIdle && state_lines(n) == 0) n = succ(n, en);
        end
        return n;
    endfunction

    state_t         state_q, state_d, nxt_state;
    logic [HW-1:0]  hcnt_q, hcnt_d, nxt_hcnt;
    logic [VW-1:0]  vcnt_q, vcnt_d, nxt_vcnt;
    logic           hs_q, hs_d, vs_q, vs_d;
    logic [7:0]     data_q, data_d, lo_q, lo_d;
    logic           fs_q, fs_d, und_q, und_d;
    logic           full_q, full_d;
    logic [15:0]    hold_q, hold_d;
    logic           nxt_hs, nxt_vs, nxt_hi;
    logic [15:0]    send_pix;

    // Position of the slot that starts at the next pclk fall.
    always_comb begin
        nxt_state = state_q;
        nxt_hcnt  = hcnt_q;
        nxt_vcnt  = vcnt_q;
        if (state_q == StIdle) begin
            if (enable_in) nxt_state = advance(StIdle, 1'b1);
        end else if (32'(hcnt_q) + 1 < LINE) begin
            nxt_hcnt = hcnt_q + HW'(1);
        end else begin
            nxt_hcnt = '0;
            if (32'(vcnt_q) + 1 < state_lines(state_q)) begin
                nxt_vcnt = vcnt_q + VW'(1);
            end else begin
                nxt_vcnt  = '0;
                nxt_state = advance(state_q, enable_in);
            end
        end
        nxt_hs = (nxt_state == StActive) && (32'(nxt_hcnt) < 2 * H_ACTIVE);
        nxt_vs = (nxt_state == StVback) || (nxt_state == StActive) || (nxt_state == StVfront);
        nxt_hi = nxt_hs && !nxt_hcnt[0];
    end

    // Slot registers advance only on the pclk falling edge; pulses last one clk.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        data_d   = data_q;
        lo_d     = lo_q;
        fs_d     = 1'b0;
        und_d    = 1'b0;
        send_pix = full_q ? hold_q : UNDERRUN_PIXEL;
        if (fall_tick) begin
            state_d = nxt_state;
            hcnt_d  = nxt_hcnt;
            vcnt_d  = nxt_vcnt;
            hs_d    = nxt_hs;
            vs_d    = nxt_vs;
            if (nxt_hi) begin
                data_d = send_pix[15:8];
                lo_d   = send_pix[7:0];
                und_d  = !full_q;
                fs_d   = (nxt_hcnt == '0) && (nxt_vcnt == '0);
            end else if (nxt_hs) begin
                data_d = lo_q;
            end else begin
                data_d = 8'h00;
            end
        end
    end

    // Holding register: a same-cycle load survives the consume of the old contents.
    always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        if (fall_tick && nxt_hi) full_d = 1'b0;
        if (valid_in && !full_q) begin
            full_d = 1'b1;
            hold_d = pixel_in;
        end
    end

    // All state clears asynchronously; a truncated frame restarts from IDLE.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            data_q  <= 8'h00;
            lo_q    <= 8'h00;
            fs_q    <= 1'b0;
            und_q   <= 1'b0;
            full_q  <= 1'b0;
            hold_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            fs_q    <= fs_d;
            und_q   <= und_d;
            full_q  <= full_d;
            hold_q  <= hold_d;
        end
    end

    // Rising-edge strobe never coincides with a slot update.
    assert property (@(posedge clk_pixel_in) disable iff (!rst_n_in) !(rise_tick && fall_tick));

    assign ready_out       = !full_q;
    assign hs_cam_out      = hs_q;
    assign vs_cam_out      = vs_q;
    assign data_cam_out    = data_q;
    assign frame_start_out = fs_q;
    assign underrun_out    = und_q;

endmodule
